div_unit: RTL and testbench

- Multi-cycle signed divider serving the DIV instruction for the multi-cycle MIPS datapath.
- Acts as the responder to the control unit's divide request: the control unit pulses a start with the A/B register values, then waits for done or a divide-by-zero indication.
- Quotient feeds the LO path and remainder feeds the HI path through the Div/Mult control muxes.
- Uses radix-2 restoring division on operand magnitudes, followed by a sign-fix step.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/div_step.sv | 16 +
 rtl/div_unit.sv | 76 +++++++
 tb/tb_div_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath constants and divider state encoding.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int DIV_ITERS = 32;
  typedef enum logic [1:0] {IDLE, RUN, FIX} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_nxt,
  output logic [W-1:0] quo_nxt
);
  logic [W+1:0] sh, trial;
  assign sh = {rem, quo[W-1]};
  assign trial = sh - {2'b00, divisor};
  assign rem_nxt = trial[W+1] ? sh[W:0] : trial[W:0];
  assign quo_nxt = {quo[W-2:0], ~trial[W+1]};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed divider; quotient to LO, remainder to HI.
module div_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int CNT_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              div_start,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_busy,
  output logic              div_done,
  output logic              div_zero
);
  import cpu_pkg::*;
  div_state_t state, state_nxt;
  logic [DATA_W:0] rem, rem_nxt;
  logic [DATA_W-1:0] quo, quo_nxt, divisor, a_mag, b_mag;
  logic [CNT_W-1:0] cnt;
  logic sign_q, sign_r, go, zero, last;
  // Magnitude of the most negative value wraps to itself and is read as unsigned 2^31.
  assign a_mag = a_in[DATA_W-1] ? -a_in : a_in;
  assign b_mag = b_in[DATA_W-1] ? -b_in : b_in;
  assign go = state == IDLE && div_start && b_in != '0;
  assign zero = state == IDLE && div_start && b_in == '0;
  assign last = cnt == CNT_W'(DIV_ITERS - 1);
  assign div_busy = state != IDLE;
  div_step #(.W(DATA_W)) u_step (
    .rem(rem),
    .quo(quo),
    .divisor(divisor),
    .rem_nxt(rem_nxt),
    .quo_nxt(quo_nxt)
  );
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (go ? RUN : IDLE) :
                state == RUN  ? (last ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      quo <= '0;
      divisor <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
      div_done <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      div_done <= state == FIX;
      div_zero <= zero;
      if (go) begin
        quo <= a_mag;
        divisor <= b_mag;
        rem <= '0;
        sign_q <= a_in[DATA_W-1] ^ b_in[DATA_W-1];
        sign_r <= a_in[DATA_W-1];
        cnt <= '0;
      end else if (state == RUN) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 1'b1;
      end else if (state == FIX) begin
        lo_out <= sign_q ? -quo : quo;
        hi_out <= sign_r ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with a scoreboard queue checked on each div_done.
module tb_div_unit;
  logic clock = 1'b0, reset = 1'b1, div_start = 1'b0;
  logic [31:0] a_in = '0, b_in = '0, hi_out, lo_out;
  logic div_busy, div_done, div_zero;
  logic [63:0] sb[$];
  int compared = 0, mismatched = 0;

  div_unit dut (
    .clock(clock), .reset(reset), .div_start(div_start),
    .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
    .div_busy(div_busy), .div_done(div_done), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && div_done) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: hi=%h lo=%h with no request outstanding", hi_out, lo_out);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        if ({hi_out, lo_out} !== e) begin
          mismatched++;
          $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h", hi_out, lo_out, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] hi,
                       input logic [31:0] lo, input bit push);
    a_in = a;
    b_in = b;
    div_start = 1'b1;
    if (push) sb.push_back({hi, lo});
    @(negedge clock);
    div_start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    while (!div_done && lat < 100) begin
      if (div_busy) busy_cnt++;
      @(negedge clock);
      lat++;
    end
    if (!div_done) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: no div_done within %0d cycles", lat);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] hi,
                     input logic [31:0] lo);
    int lat, bc;
    @(negedge clock);
    issue(a, b, hi, lo, 1'b1);
    wait_done(lat, bc);
    check("latency", 32'(lat), 32'd34);
  endtask

  initial begin
    int lat, bc;
    repeat (2) @(negedge clock);
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    check("rst_flags", {29'b0, div_busy, div_done, div_zero}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    issue(32'd7, 32'd2, 32'd1, 32'd3, 1'b1);
    wait_done(lat, bc);
    check("busy_cycles", 32'(bc), 32'd33);
    check("latency_7_2", 32'(lat), 32'd34);
    check("busy_after_done", {31'b0, div_busy}, 32'h0);
    @(negedge clock);
    check("done_pulse_width", {31'b0, div_done}, 32'h0);
    issue(32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
    check("zero_pulse", {31'b0, div_zero}, 32'h1);
    check("zero_busy", {31'b0, div_busy}, 32'h0);
    @(negedge clock);
    check("zero_pulse_end", {31'b0, div_zero}, 32'h0);
    check("zero_hi_kept", hi_out, 32'd1);
    check("zero_lo_kept", lo_out, 32'd3);
    run(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run(32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run(32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run(32'h80000000, 32'd2, 32'h0, 32'hC0000000);
    run(32'd0, 32'd9, 32'h0, 32'h0);
    @(negedge clock);
    issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    repeat (9) @(negedge clock);
    issue(32'd50, 32'd5, 32'd0, 32'd0, 1'b0);
    wait_done(lat, bc);
    check("ignored_start_lat", 32'(lat), 32'd24);
    issue(32'd50, 32'd5, 32'd0, 32'd10, 1'b1);
    wait_done(lat, bc);
    check("done_cycle_start_lat", 32'(lat), 32'd34);
    @(negedge clock);
    issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'b0, div_busy}, 32'h0);
    check("abort_hi", hi_out, 32'h0);
    check("abort_lo", lo_out, 32'h0);
    repeat (40) @(negedge clock);
    run(32'd9, 32'd4, 32'd1, 32'd2);
    repeat (3) @(negedge clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
